rmw_multi_tag: RTL and testbench

RMW_MULTI_TAG -- requirements
Module: rmw_multi_tag

---
 rtl/rmw_multi_tag.sv | 153 +++++++++++++++
 tb/tb_rmw_multi_tag.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rmw_multi_tag.sv
// rmw_multi_tag: read-modify-write engine with a tagged lookup table.
// Commands (ADDI/SUBI) allocate a tag, issue a lookup, and combine the
// out-of-order response with the stored immediate; MOVI writes back directly.
// Optional macro RMW_MULTI_TAG_SAT_EN: unsigned saturating ADDI/SUBI
// (default build wraps modulo 2^WORD_W).
module rmw_multi_tag #(
  parameter int ID_W        = 16,
  parameter int WORD_W      = 32,
  parameter int IN_FLIGHT_N = 16,
  localparam int TAG_W      = $clog2(IN_FLIGHT_N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vld,
  input  logic [ID_W-1:0]   in_id,
  input  logic [WORD_W-1:0] in_imm,
  input  logic [1:0]        in_op,
  output logic              in_accept,
  output logic              lk_vld,
  output logic [ID_W-1:0]   lk_id,
  output logic [TAG_W-1:0]  lk_tag,
  input  logic              lk_rdy,
  input  logic              rsp_vld,
  input  logic [TAG_W-1:0]  rsp_tag,
  input  logic [WORD_W-1:0] rsp_dat,
  output logic              wr_vld,
  output logic [ID_W-1:0]   wr_id,
  output logic [WORD_W-1:0] wr_dat,
  output logic [TAG_W:0]    inflight_cnt,
  output logic              err_tag
);

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_ADDI = 2'b01;
  localparam logic [1:0] OP_SUBI = 2'b10;
  localparam logic [1:0] OP_MOVI = 2'b11;

  logic [IN_FLIGHT_N-1:0] ent_vld;
  logic [IN_FLIGHT_N-1:0] ent_sub;
  logic [ID_W-1:0]        ent_id  [IN_FLIGHT_N];
  logic [WORD_W-1:0]      ent_imm [IN_FLIGHT_N];

  logic              hazard;
  logic              free_found;
  logic [TAG_W-1:0]  free_tag;
  logic              is_arith;
  logic              alloc;
  logic              movi_acc;
  logic              rsp_hit;
  logic [WORD_W-1:0] rsp_imm;
  logic              rsp_sub;
  logic [WORD_W-1:0] rsp_result;

  // Id hazard against every live entry and lowest-index free tag search
  always_comb begin
    hazard     = 1'b0;
    free_found = 1'b0;
    free_tag   = '0;
    for (int i = IN_FLIGHT_N - 1; i >= 0; i--) begin
      if (ent_vld[i] && (ent_id[i] == in_id)) hazard = 1'b1;
      if (!ent_vld[i]) begin
        free_found = 1'b1;
        free_tag   = TAG_W'(i);
      end
    end
  end

  assign is_arith = (in_op == OP_ADDI) || (in_op == OP_SUBI);

  // Command acceptance per opcode; nothing is consumed while in reset
  always_comb begin
    in_accept = 1'b0;
    if (!rst && in_vld) begin
      case (in_op)
        OP_NOP:          in_accept = 1'b1;
        OP_ADDI, OP_SUBI: in_accept = free_found && !hazard && lk_rdy;
        OP_MOVI:         in_accept = !hazard && !rsp_vld;
        default:         in_accept = 1'b0;
      endcase
    end
  end

  assign lk_vld   = in_accept && is_arith;
  assign lk_id    = in_id;
  assign lk_tag   = free_tag;
  assign alloc    = lk_vld;
  assign movi_acc = in_accept && (in_op == OP_MOVI);

  assign rsp_hit = rsp_vld && ent_vld[rsp_tag];
  assign rsp_imm = ent_imm[rsp_tag];
  assign rsp_sub = ent_sub[rsp_tag];

`ifdef RMW_MULTI_TAG_SAT_EN
  logic [WORD_W:0] sum_ext;
  logic [WORD_W:0] diff_ext;
  assign sum_ext  = {1'b0, rsp_dat} + {1'b0, rsp_imm};
  assign diff_ext = {1'b0, rsp_dat} - {1'b0, rsp_imm};

  // Saturating combine: carry clamps to all-ones, borrow clamps to zero
  always_comb begin
    if (rsp_sub) rsp_result = diff_ext[WORD_W] ? '0 : diff_ext[WORD_W-1:0];
    else         rsp_result = sum_ext[WORD_W]  ? '1 : sum_ext[WORD_W-1:0];
  end
`else
  // Wrapping combine of lookup data with the stored immediate
  always_comb begin
    if (rsp_sub) rsp_result = rsp_dat - rsp_imm;
    else         rsp_result = rsp_dat + rsp_imm;
  end
`endif

  // Valid bits, occupancy count and the single writeback slot (response wins)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_vld      <= '0;
      inflight_cnt <= '0;
      wr_vld       <= 1'b0;
      wr_id        <= '0;
      wr_dat       <= '0;
      err_tag      <= 1'b0;
    end else begin
      err_tag <= rsp_vld && !ent_vld[rsp_tag];
      if (rsp_hit) begin
        wr_vld <= 1'b1;
        wr_id  <= ent_id[rsp_tag];
        wr_dat <= rsp_result;
      end else if (movi_acc) begin
        wr_vld <= 1'b1;
        wr_id  <= in_id;
        wr_dat <= in_imm;
      end else begin
        wr_vld <= 1'b0;
      end
      if (rsp_hit) ent_vld[rsp_tag] <= 1'b0;
      if (alloc)   ent_vld[free_tag] <= 1'b1;
      case ({alloc, rsp_hit})
        2'b10:   inflight_cnt <= inflight_cnt + (TAG_W+1)'(1);
        2'b01:   inflight_cnt <= inflight_cnt - (TAG_W+1)'(1);
        default: inflight_cnt <= inflight_cnt;
      endcase
    end
  end

  // Entry payload captured on allocation; only meaningful while valid
  always_ff @(posedge clk) begin
    if (alloc) begin
      ent_id[free_tag]  <= in_id;
      ent_imm[free_tag] <= in_imm;
      ent_sub[free_tag] <= (in_op == OP_SUBI);
    end
  end

endmodule

// File: tb/tb_rmw_multi_tag.sv
// tb_rmw_multi_tag: directed scenarios plus randomized traffic against a
// tag-table reference model kept in the bench.
module tb_rmw_multi_tag;
  localparam int ID_W   = 16;
  localparam int WORD_W = 32;
  localparam int N      = 16;
  localparam int TAG_W  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_vld = 1'b0;
  logic [ID_W-1:0]   in_id = '0;
  logic [WORD_W-1:0] in_imm = '0;
  logic [1:0]        in_op = '0;
  logic              in_accept;
  logic              lk_vld;
  logic [ID_W-1:0]   lk_id;
  logic [TAG_W-1:0]  lk_tag;
  logic              lk_rdy = 1'b1;
  logic              rsp_vld = 1'b0;
  logic [TAG_W-1:0]  rsp_tag = '0;
  logic [WORD_W-1:0] rsp_dat = '0;
  logic              wr_vld;
  logic [ID_W-1:0]   wr_id;
  logic [WORD_W-1:0] wr_dat;
  logic [TAG_W:0]    inflight_cnt;
  logic              err_tag;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  bit                m_vld [N];
  logic [ID_W-1:0]   m_id  [N];
  logic [WORD_W-1:0] m_imm [N];
  bit                m_sub [N];
  int                m_cnt;
  bit                e_accept, e_lk_vld, e_wr_vld, e_err;
  int                e_lk_tag;
  logic [ID_W-1:0]   e_wr_id;
  logic [WORD_W-1:0] e_wr_dat;

  rmw_multi_tag #(.ID_W(ID_W), .WORD_W(WORD_W), .IN_FLIGHT_N(N)) dut (
    .clk(clk), .rst(rst),
    .in_vld(in_vld), .in_id(in_id), .in_imm(in_imm), .in_op(in_op),
    .in_accept(in_accept),
    .lk_vld(lk_vld), .lk_id(lk_id), .lk_tag(lk_tag), .lk_rdy(lk_rdy),
    .rsp_vld(rsp_vld), .rsp_tag(rsp_tag), .rsp_dat(rsp_dat),
    .wr_vld(wr_vld), .wr_id(wr_id), .wr_dat(wr_dat),
    .inflight_cnt(inflight_cnt), .err_tag(err_tag)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish (got running, exp finished)");
    $fatal(1);
  end

  function automatic logic [WORD_W-1:0] ref_calc(bit sub, logic [WORD_W-1:0] dat, logic [WORD_W-1:0] imm);
    longint a, b, r, maxv;
    a = dat;
    b = imm;
    maxv = (longint'(1) << WORD_W) - 1;
    r = sub ? (a - b) : (a + b);
`ifdef RMW_MULTI_TAG_SAT_EN
    if (r < 0) r = 0;
    if (r > maxv) r = maxv;
`else
    r = r & maxv;
`endif
    return r[WORD_W-1:0];
  endfunction

  task automatic model_reset();
    foreach (m_vld[i]) m_vld[i] = 1'b0;
    m_cnt = 0; e_wr_vld = 0; e_err = 0; e_wr_id = '0; e_wr_dat = '0;
    e_accept = 0; e_lk_vld = 0; e_lk_tag = 0;
  endtask

  task automatic model_eval();
    int fr;
    bit hz;
    fr = -1; hz = 0;
    for (int i = 0; i < N; i++) begin
      if (m_vld[i] && m_id[i] == in_id) hz = 1;
      if (!m_vld[i] && fr < 0) fr = i;
    end
    e_accept = 0;
    if (!rst && in_vld) begin
      if (in_op == 2'd0) e_accept = 1;
      else if (in_op == 2'd3) e_accept = !hz && !rsp_vld;
      else e_accept = (fr >= 0) && !hz && lk_rdy;
    end
    e_lk_vld = e_accept && (in_op == 2'd1 || in_op == 2'd2);
    e_lk_tag = fr;
  endtask

  task automatic model_commit();
    bit hit;
    hit = rsp_vld && m_vld[rsp_tag];
    e_err = rsp_vld && !hit;
    if (hit) begin
      e_wr_vld = 1; e_wr_id = m_id[rsp_tag];
      e_wr_dat = ref_calc(m_sub[rsp_tag], rsp_dat, m_imm[rsp_tag]);
      m_vld[rsp_tag] = 0; m_cnt--;
    end else if (e_accept && in_op == 2'd3) begin
      e_wr_vld = 1; e_wr_id = in_id; e_wr_dat = in_imm;
    end else begin
      e_wr_vld = 0;
    end
    if (e_lk_vld) begin
      m_vld[e_lk_tag] = 1; m_id[e_lk_tag] = in_id; m_imm[e_lk_tag] = in_imm;
      m_sub[e_lk_tag] = (in_op == 2'd2); m_cnt++;
    end
  endtask

  task automatic drive(bit a_v, logic [1:0] a_op, logic [ID_W-1:0] a_id, logic [WORD_W-1:0] a_imm,
                       bit a_rv, logic [TAG_W-1:0] a_rtag, logic [WORD_W-1:0] a_rdat, bit a_rdy);
    @(negedge clk);
    in_vld = a_v; in_op = a_op; in_id = a_id; in_imm = a_imm;
    rsp_vld = a_rv; rsp_tag = a_rtag; rsp_dat = a_rdat; lk_rdy = a_rdy;
    #1;
    model_eval();
  endtask

  task automatic tick();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 2'd0, '0, '0, 1'b0, '0, '0, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_vld = 0; rsp_vld = 0;
    #1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; in_vld = 1'b1; in_op = 2'd1; in_id = 16'd1; lk_rdy = 1'b1;
    #1;
    model_reset();
    n_tests++; if (in_accept !== 1'b0) begin n_fail++; $display("FAIL reset_in_accept got=%0b exp=0", in_accept); end
    n_tests++; if (lk_vld !== 1'b0) begin n_fail++; $display("FAIL reset_lk_vld got=%0b exp=0", lk_vld); end
    n_tests++; if (inflight_cnt !== '0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", inflight_cnt); end
    n_tests++; if (wr_vld !== 1'b0 || err_tag !== 1'b0) begin n_fail++; $display("FAIL reset_flags got=%0b%0b exp=00", wr_vld, err_tag); end
    n_tests++; if (wr_id !== '0 || wr_dat !== '0) begin n_fail++; $display("FAIL reset_wr got=%0h/%0h exp=0/0", wr_id, wr_dat); end
    @(negedge clk);
    in_vld = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    drive(1'b1, 2'd1, 16'd5, 32'd3, 1'b0, '0, '0, 1'b1);
    n_tests++; if (in_accept !== 1'b1 || lk_vld !== 1'b1) begin n_fail++; $display("FAIL basic_accept got=%0b%0b exp=11", in_accept, lk_vld); end
    n_tests++; if (lk_tag !== 4'd0 || lk_id !== 16'd5) begin n_fail++; $display("FAIL basic_lk got tag=%0d id=%0d exp tag=0 id=5", lk_tag, lk_id); end
    tick();
    n_tests++; if (inflight_cnt !== 5'd1) begin n_fail++; $display("FAIL basic_cnt1 got=%0d exp=1", inflight_cnt); end
    drive(1'b0, 2'd0, '0, '0, 1'b1, 4'd0, 32'd10, 1'b1);
    tick();
    n_tests++; if (wr_vld !== 1'b1 || wr_id !== 16'd5 || wr_dat !== 32'd13) begin n_fail++; $display("FAIL basic_wb got vld=%0b id=%0d dat=%0d exp 1/5/13", wr_vld, wr_id, wr_dat); end
    n_tests++; if (inflight_cnt !== 5'd0) begin n_fail++; $display("FAIL basic_cnt0 got=%0d exp=0", inflight_cnt); end
    idle(); tick();
    n_tests++; if (wr_vld !== 1'b0 || wr_id !== 16'd5 || wr_dat !== 32'd13) begin n_fail++; $display("FAIL basic_hold got vld=%0b id=%0d dat=%0d exp 0/5/13", wr_vld, wr_id, wr_dat); end
  endtask

  task automatic test_fill_reverse();
    for (int i = 0; i < N; i++) begin
      drive(1'b1, 2'd1, ID_W'(100 + i), WORD_W'(i), 1'b0, '0, '0, 1'b1);
      n_tests++; if (in_accept !== 1'b1 || lk_tag !== TAG_W'(i)) begin n_fail++; $display("FAIL fill_tag got acc=%0b tag=%0d exp acc=1 tag=%0d", in_accept, lk_tag, i); end
      tick();
    end
    drive(1'b1, 2'd1, 16'd200, 32'd0, 1'b0, '0, '0, 1'b1);
    n_tests++; if (in_accept !== 1'b0 || lk_vld !== 1'b0) begin n_fail++; $display("FAIL fill_stall got=%0b%0b exp=00", in_accept, lk_vld); end
    tick();
    n_tests++; if (inflight_cnt !== 5'd16) begin n_fail++; $display("FAIL fill_cnt got=%0d exp=16", inflight_cnt); end
    for (int t = N - 1; t >= 0; t--) begin
      drive(1'b0, 2'd0, '0, '0, 1'b1, TAG_W'(t), 32'd1000, 1'b1);
      tick();
      n_tests++; if (wr_vld !== 1'b1 || wr_id !== ID_W'(100 + t) || wr_dat !== WORD_W'(1000 + t)) begin
        n_fail++; $display("FAIL fill_wb got vld=%0b id=%0d dat=%0d exp 1/%0d/%0d", wr_vld, wr_id, wr_dat, 100 + t, 1000 + t); end
    end
    n_tests++; if (inflight_cnt !== 5'd0) begin n_fail++; $display("FAIL fill_drain got=%0d exp=0", inflight_cnt); end
  endtask

  task automatic test_hazard();
    drive(1'b1, 2'd1, 16'd7, 32'd1, 1'b0, '0, '0, 1'b1); tick();
    drive(1'b1, 2'd2, 16'd7, 32'd2, 1'b0, '0, '0, 1'b1);
    n_tests++; if (in_accept !== 1'b0 || lk_vld !== 1'b0) begin n_fail++; $display("FAIL haz_subi got=%0b%0b exp=00", in_accept, lk_vld); end
    tick();
    drive(1'b1, 2'd3, 16'd7, 32'd55, 1'b0, '0, '0, 1'b1);
    n_tests++; if (in_accept !== 1'b0) begin n_fail++; $display("FAIL haz_movi got=%0b exp=0", in_accept); end
    tick();
    n_tests++; if (wr_vld !== 1'b0) begin n_fail++; $display("FAIL haz_no_wb got=%0b exp=0", wr_vld); end
    drive(1'b1, 2'd2, 16'd7, 32'd2, 1'b1, 4'd0, 32'd100, 1'b1);
    n_tests++; if (in_accept !== 1'b0) begin n_fail++; $display("FAIL haz_freeing got=%0b exp=0", in_accept); end
    tick();
    n_tests++; if (wr_vld !== 1'b1 || wr_id !== 16'd7 || wr_dat !== 32'd101) begin n_fail++; $display("FAIL haz_wb got %0b/%0d/%0d exp 1/7/101", wr_vld, wr_id, wr_dat); end
    drive(1'b1, 2'd3, 16'd7, 32'd55, 1'b0, '0, '0, 1'b1);
    n_tests++; if (in_accept !== 1'b1) begin n_fail++; $display("FAIL haz_movi_after got=%0b exp=1", in_accept); end
    tick();
    n_tests++; if (wr_vld !== 1'b1 || wr_dat !== 32'd55) begin n_fail++; $display("FAIL haz_movi_wb got %0b/%0d exp 1/55", wr_vld, wr_dat); end
    drive(1'b1, 2'd2, 16'd7, 32'd2, 1'b0, '0, '0, 1'b1);
    n_tests++; if (in_accept !== 1'b1 || lk_tag !== 4'd0) begin n_fail++; $display("FAIL haz_subi_after got acc=%0b tag=%0d exp 1/0", in_accept, lk_tag); end
    tick();
    drive(1'b0, 2'd0, '0, '0, 1'b1, 4'd0, 32'd100, 1'b1); tick();
    n_tests++; if (wr_vld !== 1'b1 || wr_dat !== 32'd98) begin n_fail++; $display("FAIL haz_subi_wb got %0b/%0d exp 1/98", wr_vld, wr_dat); end
  endtask

  task automatic test_movi_rsp();
    drive(1'b1, 2'd1, 16'd20, 32'd4, 1'b0, '0, '0, 1'b1); tick();
    drive(1'b1, 2'd3, 16'd2, 32'd9, 1'b1, 4'd0, 32'd6, 1'b1);
    n_tests++; if (in_accept !== 1'b0) begin n_fail++; $display("FAIL movi_rsp_stall got=%0b exp=0", in_accept); end
    tick();
    n_tests++; if (wr_vld !== 1'b1 || wr_id !== 16'd20 || wr_dat !== 32'd10) begin n_fail++; $display("FAIL movi_rsp_first got %0b/%0d/%0d exp 1/20/10", wr_vld, wr_id, wr_dat); end
    drive(1'b1, 2'd3, 16'd2, 32'd9, 1'b0, '0, '0, 1'b1);
    n_tests++; if (in_accept !== 1'b1) begin n_fail++; $display("FAIL movi_rsp_accept got=%0b exp=1", in_accept); end
    tick();
    n_tests++; if (wr_vld !== 1'b1 || wr_id !== 16'd2 || wr_dat !== 32'd9) begin n_fail++; $display("FAIL movi_rsp_second got %0b/%0d/%0d exp 1/2/9", wr_vld, wr_id, wr_dat); end
  endtask

  task automatic test_wrap();
    logic [WORD_W-1:0] exp_sub, exp_add;
`ifdef RMW_MULTI_TAG_SAT_EN
    exp_sub = 32'h0000_0000; exp_add = 32'hFFFF_FFFF;
`else
    exp_sub = 32'hFFFF_FFFE; exp_add = 32'h0000_0000;
`endif
    drive(1'b1, 2'd2, 16'd30, 32'd5, 1'b0, '0, '0, 1'b1); tick();
    drive(1'b0, 2'd0, '0, '0, 1'b1, 4'd0, 32'd3, 1'b1); tick();
    n_tests++; if (wr_vld !== 1'b1 || wr_dat !== exp_sub) begin n_fail++; $display("FAIL wrap_subi got %0b/%0h exp 1/%0h", wr_vld, wr_dat, exp_sub); end
    drive(1'b1, 2'd1, 16'd31, 32'd1, 1'b0, '0, '0, 1'b1); tick();
    drive(1'b0, 2'd0, '0, '0, 1'b1, 4'd0, 32'hFFFF_FFFF, 1'b1); tick();
    n_tests++; if (wr_vld !== 1'b1 || wr_dat !== exp_add) begin n_fail++; $display("FAIL wrap_addi got %0b/%0h exp 1/%0h", wr_vld, wr_dat, exp_add); end
  endtask

  task automatic test_err_tag();
    drive(1'b0, 2'd0, '0, '0, 1'b1, 4'd3, 32'd77, 1'b1); tick();
    n_tests++; if (err_tag !== 1'b1 || wr_vld !== 1'b0) begin n_fail++; $display("FAIL err_pulse got err=%0b wr=%0b exp 1/0", err_tag, wr_vld); end
    n_tests++; if (inflight_cnt !== 5'd0) begin n_fail++; $display("FAIL err_cnt got=%0d exp=0", inflight_cnt); end
    idle(); tick();
    n_tests++; if (err_tag !== 1'b0) begin n_fail++; $display("FAIL err_one_cycle got=%0b exp=0", err_tag); end
  endtask

  task automatic test_reset_flight();
    drive(1'b1, 2'd1, 16'd40, 32'd1, 1'b0, '0, '0, 1'b1); tick();
    n_tests++; if (inflight_cnt !== 5'd1) begin n_fail++; $display("FAIL rflight_cnt got=%0d exp=1", inflight_cnt); end
    do_reset();
    drive(1'b0, 2'd0, '0, '0, 1'b1, 4'd0, 32'd5, 1'b1); tick();
    n_tests++; if (err_tag !== 1'b1 || wr_vld !== 1'b0 || inflight_cnt !== 5'd0) begin
      n_fail++; $display("FAIL rflight_err got err=%0b wr=%0b cnt=%0d exp 1/0/0", err_tag, wr_vld, inflight_cnt); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      int q[$];
      logic [TAG_W-1:0] rt;
      for (int i = 0; i < N; i++) if (m_vld[i]) q.push_back(i);
      if (q.size() > 0 && $urandom_range(0, 7) != 0) rt = TAG_W'(q[$urandom_range(0, q.size() - 1)]);
      else rt = TAG_W'($urandom_range(0, N - 1));
      drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), ID_W'($urandom_range(0, 23)), WORD_W'($urandom),
            $urandom_range(0, 2) == 0, rt, WORD_W'($urandom), $urandom_range(0, 3) != 0);
      n_tests++; if (in_accept !== e_accept || lk_vld !== e_lk_vld) begin
        n_fail++; $display("FAIL rand_accept c=%0d got=%0b%0b exp=%0b%0b", c, in_accept, lk_vld, e_accept, e_lk_vld); end
      if (e_lk_vld) begin
        n_tests++; if (lk_tag !== TAG_W'(e_lk_tag) || lk_id !== in_id) begin
          n_fail++; $display("FAIL rand_lk c=%0d got tag=%0d exp tag=%0d", c, lk_tag, e_lk_tag); end
      end
      tick();
      n_tests++; if (wr_vld !== e_wr_vld || wr_id !== e_wr_id || wr_dat !== e_wr_dat) begin
        n_fail++; $display("FAIL rand_wb c=%0d got %0b/%0h/%0h exp %0b/%0h/%0h", c, wr_vld, wr_id, wr_dat, e_wr_vld, e_wr_id, e_wr_dat); end
      n_tests++; if (err_tag !== e_err || inflight_cnt !== (TAG_W+1)'(m_cnt)) begin
        n_fail++; $display("FAIL rand_state c=%0d got err=%0b cnt=%0d exp err=%0b cnt=%0d", c, err_tag, inflight_cnt, e_err, m_cnt); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_fill_reverse();
    test_hazard();
    test_movi_rsp();
    test_wrap();
    test_err_tag();
    test_reset_flight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
